irda_mode_ctrl: RTL and testbench
=================================

IRDA_MODE_CTRL -- requirements
Module: irda_mode_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: core-reset/settle length after a mode change, range 2..255.
REQ-002 Parameter MASTER_ADDR, default 4'h8: word address of the MASTER register.
REQ-003 wb_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  host Wishbone strobe, cycle, write enable.
REQ-006 wb_addr_i  in  4  host word address; wb_dat_i  in  32  host write data.
REQ-007 wb_ack_o  out  1  host acknowledge; wb_dat_o  out  32  host read data.
REQ-008 r_wb_stb_o, r_wb_cyc_o  out  1 each  gated strobe and cycle to the downstream router.
REQ-009 r_wb_ack_i  in  1, r_wb_dat_i  in  32  acknowledge and read data returned by the router.
REQ-010 fast_mode  out  1  mode select to router: 1 = fast (MIR/FIR) core, 0 = UART (SIR) core.
REQ-011 f_core_rst_o, u_core_rst_o  out  1 each  local reset to fast core and UART core.

Function
REQ-012 Master hit = wb_stb_i & wb_cyc_i & (wb_addr_i == MASTER_ADDR); the block SHALL service master hits itself and SHALL never forward them.
REQ-013 r_wb_stb_o = wb_stb_i & wb_cyc_i & ~master-hit & (state == IDLE); r_wb_cyc_o same with wb_stb_i removed; both combinational.
REQ-014 Non-master accesses outside IDLE SHALL stall: no forward, no ack, until IDLE is re-entered.
REQ-015 Master ack: registered one-cycle pulse, m_ack <= master-hit & ~m_ack; asserted the cycle after the strobe, in every state.
REQ-016 wb_ack_o = m_ack | (r_wb_ack_i & r_wb_stb_o).
REQ-017 wb_dat_o = {29'b0, req_mode, busy, fast_mode} during m_ack, else r_wb_dat_i; busy = (state != IDLE).
REQ-018 A master write is accepted on the cycle m_ack is asserted; accepted write updates req_mode <= wb_dat_i[0] only in IDLE.
REQ-019 FSM states: IDLE, DRAIN, SWAP, SETTLE.
REQ-020 IDLE -> DRAIN on accepted master write with wb_dat_i[0] != fast_mode; equal value: stay IDLE, no reset pulse.
REQ-021 DRAIN -> SWAP on first cycle with wb_cyc_i == 0; holds indefinitely while wb_cyc_i == 1.
REQ-022 SWAP (exactly one cycle): fast_mode <= req_mode; counter <= SETTLE_CYCLES-1; -> SETTLE.
REQ-023 SETTLE: counter decrements each cycle; at counter == 0 -> IDLE the following cycle.
REQ-024 f_core_rst_o and u_core_rst_o SHALL be registered, high exactly while state is SWAP or SETTLE (SETTLE_CYCLES+1 cycles total), low otherwise.
REQ-025 Master writes while busy: acked normally, req_mode and FSM unchanged (write discarded).
REQ-026 Master reads permitted in every state; busy bit reflects state at time of ack.
REQ-027 fast_mode changes only in SWAP; it is stable in all other states.
REQ-028 Counter width 8 bits; no wrap: reload only in SWAP.

Reset
REQ-029 While wb_rst_i is high on a clock edge: state <= IDLE, fast_mode <= 0, req_mode <= 0, m_ack <= 0, counter <= 0, f_core_rst_o <= 0, u_core_rst_o <= 0.
REQ-030 Reset asserted mid-switch (DRAIN/SWAP/SETTLE) SHALL abort the switch; fast_mode returns to 0 regardless of req_mode.
REQ-031 Outputs are undefined before the first reset edge; combinational outputs follow REQ-013/016/017 from reset state.

Verification
REQ-032 After reset, read MASTER_ADDR -> ack one cycle after strobe, wb_dat_o = 32'h0; no r_wb_stb_o pulse.
REQ-033 Write MASTER=1, host drops cyc after ack -> DRAIN 1 cycle, SWAP, core resets high 17 cycles, fast_mode = 1 from SWAP+1; subsequent read returns 32'h5.
REQ-034 Write MASTER=0 while fast_mode=0 -> ack only, state stays IDLE, no core reset pulse.
REQ-035 Non-master read at addr 4'h2 issued during SETTLE -> r_wb_stb_o held 0, no ack until IDLE, then forwarded; wb_dat_o = r_wb_dat_i on router ack.
REQ-036 Master write 0 during SETTLE (switch to fast pending) -> acked, discarded; fast_mode ends 1; readback bit2 = 1.
REQ-037 wb_rst_i pulsed on 5th SETTLE cycle -> next cycle all resets low, fast_mode 0, state IDLE, read returns 32'h0.

Source files
------------

// File: rtl/irda_mode_ctrl.sv
// IrDA mode controller.
// Owns the MASTER register that selects between the fast (MIR/FIR) core and
// the UART (SIR) core, and sequences a safe switch between them:
//   IDLE   -> normal operation, host traffic forwarded to the router
//   DRAIN  -> wait for the host to close its bus cycle
//   SWAP   -> one cycle, flip the mode select and load the settle counter
//   SETTLE -> both cores held in reset while the new path settles
// Host accesses to MASTER_ADDR are always serviced locally; every other
// access is forwarded only while IDLE and stalls otherwise.
module irda_mode_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [3:0]  MASTER_ADDR   = 4'h8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // host side
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_addr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  // router side
  output logic        r_wb_stb_o,
  output logic        r_wb_cyc_o,
  input  logic        r_wb_ack_i,
  input  logic [31:0] r_wb_dat_i,
  // mode select and core resets
  output logic        fast_mode,
  output logic        f_core_rst_o,
  output logic        u_core_rst_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SWAP   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  // SWAP loads N-1 so that SETTLE lasts N cycles (counting down to 0).
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  // Read-back layout of the MASTER register.
  typedef struct packed {
    logic [28:0] rsvd;
    logic        req_mode;
    logic        busy;
    logic        fast;
  } master_stat_t;

  logic [1:0] state_q, state_d;
  logic       fast_q, fast_d;
  logic       req_q, req_d;
  logic       m_ack_q, m_ack_d;
  logic [7:0] cnt_q, cnt_d;
  logic       core_rst_q, core_rst_d;

  logic         master_hit;
  logic         idle;
  logic         wr_accept;
  master_stat_t stat;

  // Only bit 0 of the write data is meaningful for the MASTER register.
  logic unused_wdat;
  assign unused_wdat = ^wb_dat_i[31:1];

  assign master_hit = wb_stb_i & wb_cyc_i & (wb_addr_i == MASTER_ADDR);
  assign idle       = (state_q == ST_IDLE);

  // The write lands on the ack cycle, while the host still holds the strobe.
  assign wr_accept  = m_ack_q & master_hit & wb_we_i;

  // Forwarding gate: never pass MASTER hits, and hold everything else off
  // while a switch is in progress so no access reaches a core in reset.
  assign r_wb_stb_o = wb_stb_i & wb_cyc_i & ~master_hit & idle;
  assign r_wb_cyc_o = wb_cyc_i & ~master_hit & idle;

  // Ack merges the local MASTER ack with acks from forwarded accesses only.
  assign wb_ack_o = m_ack_q | (r_wb_ack_i & r_wb_stb_o);

  always_comb begin
    stat          = '0;
    stat.req_mode = req_q;
    stat.busy     = ~idle;
    stat.fast     = fast_q;
  end

  assign wb_dat_o = m_ack_q ? stat : r_wb_dat_i;

  assign fast_mode    = fast_q;
  assign f_core_rst_o = core_rst_q;
  assign u_core_rst_o = core_rst_q;

  // Single-cycle ack pulse; a held strobe produces alternating acks.
  assign m_ack_d = master_hit & ~m_ack_q;

  // Mode-switch sequencer and MASTER register update.
  always_comb begin
    state_d = state_q;
    fast_d  = fast_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // Writes are only honoured here; a busy write is acked and dropped.
        if (wr_accept) begin
          req_d = wb_dat_i[0];
          if (wb_dat_i[0] != fast_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Let the host finish whatever cycle it has open before switching.
        if (!wb_cyc_i) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        fast_d  = req_q;
        cnt_d   = SETTLE_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Counter parks at zero; it is only ever reloaded in SWAP.
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core resets are registered from the next state so they line up exactly
  // with the SWAP and SETTLE cycles.
  assign core_rst_d = (state_d == ST_SWAP) | (state_d == ST_SETTLE);

  // State registers; reset also aborts any switch in progress.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      fast_q     <= 1'b0;
      req_q      <= 1'b0;
      m_ack_q    <= 1'b0;
      cnt_q      <= 8'd0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fast_q     <= fast_d;
      req_q      <= req_d;
      m_ack_q    <= m_ack_d;
      cnt_q      <= cnt_d;
      core_rst_q <= core_rst_d;
    end
  end

endmodule

// File: tb/tb_irda_mode_ctrl.sv
// Bench for irda_mode_ctrl: table of simple IDLE accesses, then hand-written
// mode-switch sequences. Read data is checked by a scoreboard popped on ack.
module tb_irda_mode_ctrl;

  localparam logic [3:0] MADDR  = 4'h8;
  localparam int         SETTLE = 16;

  logic        clk = 1'b0;
  logic        wb_rst_i, wb_stb_i, wb_cyc_i, wb_we_i;
  logic [3:0]  wb_addr_i;
  logic [31:0] wb_dat_i, wb_dat_o, r_wb_dat_i;
  logic        wb_ack_o, r_wb_stb_o, r_wb_cyc_o, r_wb_ack_i;
  logic        fast_mode, f_core_rst_o, u_core_rst_o;

  irda_mode_ctrl #(.SETTLE_CYCLES(SETTLE), .MASTER_ADDR(MADDR)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .r_wb_stb_o(r_wb_stb_o), .r_wb_cyc_o(r_wb_cyc_o),
    .r_wb_ack_i(r_wb_ack_i), .r_wb_dat_i(r_wb_dat_i),
    .fast_mode(fast_mode), .f_core_rst_o(f_core_rst_o), .u_core_rst_o(u_core_rst_o)
  );

  always #5 clk = ~clk;

  // Router model: zero-wait ack, data tagged with the address.
  assign r_wb_ack_i = r_wb_stb_o;
  assign r_wb_dat_i = 32'hC0DE_0000 | {28'd0, wb_addr_i};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       nm;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0]  addr;
    logic        we;
    logic [31:0] dat;
    int          lat;
    logic        chk;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  int run_len  = 0;
  int last_run = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ack consumes one expected entry.
  always @(negedge clk) begin
    if (wb_ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        cmp("unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.chk) cmp({"rdata_", e.nm}, wb_dat_o, e.exp);
      end
    end
  end

  // Track length of core-reset pulses and that both resets agree.
  always @(negedge clk) begin
    if (f_core_rst_o === 1'b1 || u_core_rst_o === 1'b1)
      cmp("rst_pair", {31'd0, u_core_rst_o}, {31'd0, f_core_rst_o});
    if (f_core_rst_o === 1'b1) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  // One host access; returns cycles from strobe to ack.
  task automatic bus(input logic [3:0] a, input logic we, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp, input string nm,
                     output int lat);
    logic fwd_bad;
    sb_q.push_back('{chk, exp, nm});
    wb_addr_i = a; wb_we_i = we; wb_dat_i = d;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    #1;
    lat = 0;
    fwd_bad = 1'b0;
    while (wb_ack_o !== 1'b1 && lat < 400) begin
      if (r_wb_stb_o === 1'b1 && (a == MADDR || f_core_rst_o === 1'b1)) fwd_bad = 1'b1;
      tick();
      lat++;
    end
    if (a == MADDR && r_wb_stb_o === 1'b1) fwd_bad = 1'b1;
    cmp({"fwd_", nm}, {31'd0, fwd_bad}, 32'd0);
    cmp({"acked_", nm}, {31'd0, wb_ack_o}, 32'd1);
    tick();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int lat;
    int n;

    vt[0] = '{MADDR, 1'b0, 32'd0,          1, 1'b1, 32'h0000_0000, "rd_master0"};
    vt[1] = '{4'h2,  1'b0, 32'd0,          0, 1'b1, 32'hC0DE_0002, "rd_r2"};
    vt[2] = '{MADDR, 1'b1, 32'd0,          1, 1'b0, 32'd0,         "wr_master_same"};
    vt[3] = '{MADDR, 1'b0, 32'd0,          1, 1'b1, 32'h0000_0000, "rd_master1"};
    vt[4] = '{4'h3,  1'b1, 32'hDEAD_BEEF,  0, 1'b0, 32'd0,         "wr_r3"};
    vt[5] = '{4'hF,  1'b0, 32'd0,          0, 1'b1, 32'hC0DE_000F, "rd_rF"};

    wb_rst_i = 1'b1; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_addr_i = 4'h0; wb_dat_i = 32'd0;
    repeat (3) tick();
    wb_rst_i = 1'b0;
    #1;
    cmp("rst_fast",  {31'd0, fast_mode},    32'd0);
    cmp("rst_frst",  {31'd0, f_core_rst_o}, 32'd0);
    cmp("rst_urst",  {31'd0, u_core_rst_o}, 32'd0);
    cmp("rst_ack",   {31'd0, wb_ack_o},     32'd0);
    cmp("rst_rstb",  {31'd0, r_wb_stb_o},   32'd0);
    cmp("rst_rcyc",  {31'd0, r_wb_cyc_o},   32'd0);

    // IDLE traffic in UART mode, including a same-value MASTER write.
    for (int i = 0; i < 6; i++) begin
      bus(vt[i].addr, vt[i].we, vt[i].dat, vt[i].chk, vt[i].exp, vt[i].nm, lat);
      cmp({"lat_", vt[i].nm}, lat, vt[i].lat);
    end
    tick();
    cmp("no_rst_pulse", last_run, 32'd0);
    cmp("still_uart", {31'd0, fast_mode}, 32'd0);

    // Switch to fast; discarded write and busy read during SETTLE.
    bus(MADDR, 1'b1, 32'd1, 1'b0, 32'd0, "wr_fast", lat);
    cmp("lat_wr_fast", lat, 1);
    cmp("drain_rst",  {31'd0, f_core_rst_o}, 32'd0);
    cmp("drain_fast", {31'd0, fast_mode},    32'd0);
    tick();
    cmp("swap_rst",   {31'd0, f_core_rst_o}, 32'd1);
    cmp("swap_fast",  {31'd0, fast_mode},    32'd0);
    tick();
    cmp("settle_fast", {31'd0, fast_mode},   32'd1);
    bus(MADDR, 1'b1, 32'd0, 1'b0, 32'd0, "wr_busy", lat);
    cmp("lat_wr_busy", lat, 1);
    bus(MADDR, 1'b0, 32'd0, 1'b1, 32'h0000_0007, "rd_busy", lat);
    n = 0;
    while (f_core_rst_o === 1'b1 && n < 400) begin tick(); n++; end
    tick();
    cmp("run_fast", last_run, SETTLE + 1);
    bus(MADDR, 1'b0, 32'd0, 1'b1, 32'h0000_0005, "rd_fast", lat);
    cmp("lat_rd_fast", lat, 1);

    // Switch back with the host holding cyc in DRAIN, then a stalled read.
    bus(MADDR, 1'b1, 32'd0, 1'b0, 32'd0, "wr_uart", lat);
    wb_cyc_i = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (f_core_rst_o !== 1'b0 || fast_mode !== 1'b1) n++;
    end
    cmp("drain_hold", n, 0);
    wb_cyc_i = 1'b0;
    tick();
    cmp("swap2_rst",  {31'd0, f_core_rst_o}, 32'd1);
    cmp("swap2_fast", {31'd0, fast_mode},    32'd1);
    tick();
    cmp("settle2_fast", {31'd0, fast_mode},  32'd0);
    bus(4'h2, 1'b0, 32'd0, 1'b1, 32'hC0DE_0002, "rd_stall", lat);
    cmp("lat_rd_stall", lat, SETTLE);
    tick();
    cmp("run_uart", last_run, SETTLE + 1);
    bus(MADDR, 1'b0, 32'd0, 1'b1, 32'h0000_0000, "rd_uart", lat);

    // Reset on the 5th SETTLE cycle aborts the switch to fast.
    bus(MADDR, 1'b1, 32'd1, 1'b0, 32'd0, "wr_fast2", lat);
    tick();
    tick();
    repeat (4) tick();
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    cmp("abort_frst", {31'd0, f_core_rst_o}, 32'd0);
    cmp("abort_urst", {31'd0, u_core_rst_o}, 32'd0);
    cmp("abort_fast", {31'd0, fast_mode},    32'd0);
    bus(MADDR, 1'b0, 32'd0, 1'b1, 32'h0000_0000, "rd_abort", lat);
    cmp("lat_rd_abort", lat, 1);
    cmp("run_abort", last_run, 6);

    tick();
    cmp("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
